// File: rtl/uart_ascii2dec_if.sv
// Bus bundle for uart_ascii2dec: serial line in, digit codes and strobes out.
interface uart_ascii2dec_if;
  logic       rx;
  logic [3:0] o_dec;
  logic       o_rd;
  logic       o_err;

  modport master (output rx, input o_dec, o_rd, o_err);
  modport slave  (input rx, output o_dec, o_rd, o_err);
endinterface

// File: rtl/uart_ascii2dec.sv
// UART receiver that turns ASCII digits/space into 3-entry bursts of decimal codes.
// Define UART_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_ascii2dec #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic             clk,
  input logic             rst,
  uart_ascii2dec_if.slave bus
);

  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BURST} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BURST} state_t;
`endif

  state_t          state_q, state_d;
  logic            rx_meta, rx_sync, line_high, fall;
  logic [1:0]      sync_ok;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0][3:0] buf_q, buf_d;
  logic [1:0]      fill_q, fill_d;
  logic [1:0]      phase_q, phase_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic            par_fail;
  logic [3:0]      code;
  logic [3:0]      dec;

  // line_high only becomes true once the synchronizer holds a real post-reset
  // sample, so a line already low at reset release never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_ok   <= 2'b00;
      line_high <= 1'b0;
    end else begin
      rx_meta   <= bus.rx;
      rx_sync   <= rx_meta;
      sync_ok   <= {sync_ok[0], 1'b1};
      line_high <= sync_ok[1] & rx_sync;
    end
  end

  assign fall = line_high & ~rx_sync;

`ifdef UART_PARITY_EN
  logic par_bad_q, par_bad_d;
  assign par_fail = par_bad_q;
`else
  assign par_fail = 1'b0;
`endif

  assign code = (shreg_q == 8'h20) ? 4'hF : shreg_q[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      buf_q   <= {3{4'hF}};
      fill_q  <= '0;
      phase_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
`ifdef UART_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // A falling edge seen during BURST is remembered in pend with the baud counter
  // already running, so IDLE hands it straight to START without losing phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    phase_d = 2'd0;
    pend_d  = pend_q;
    err_d   = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall || pend_q) begin
          state_d = START;
          pend_d  = 1'b0;
          cnt_d   = pend_q ? cnt_q + 16'd1 : 16'd0;
        end
      end
      START: begin
        if (cnt_q >= HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? IDLE : DATA;
`ifdef UART_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shreg_d = {rx_sync, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          par_bad_d = (^shreg_q) ^ rx_sync;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_sync || par_fail) begin
            err_d = 1'b1;
          end else if ((shreg_q >= 8'h30 && shreg_q <= 8'h39) || shreg_q == 8'h20) begin
            case (fill_q)
              2'd0:    buf_d[0] = code;
              2'd1:    buf_d[1] = code;
              default: buf_d[2] = code;
            endcase
            fill_d = fill_q + 2'd1;
            if (fill_q == 2'd2) state_d = BURST;
          end else if (shreg_q == 8'h0D || shreg_q == 8'h0A) begin
            if (fill_q != 2'd0) state_d = BURST;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BURST: begin
        phase_d = phase_q + 2'd1;
        if (fall) begin
          pend_d = 1'b1;
          cnt_d  = '0;
        end else if (pend_q) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (phase_q == 2'd3) begin
          state_d = IDLE;
          fill_d  = '0;
          buf_d   = {3{4'hF}};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // o_dec trails o_rd by one cycle so each strobe is followed by its digit
  always_comb begin
    dec = 4'hF;
    if (state_q == BURST) begin
      case (phase_q)
        2'd1:    dec = buf_q[0];
        2'd2:    dec = buf_q[1];
        2'd3:    dec = buf_q[2];
        default: dec = 4'hF;
      endcase
    end
  end

  assign bus.o_dec = dec;
  assign bus.o_rd  = (state_q == BURST) && (phase_q != 2'd3);
  assign bus.o_err = err_q;

endmodule

// File: doc/uart_ascii2dec.md
UART_ASCII2DEC -- requirements
Module: uart_ascii2dec

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  UART serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port o_dec  output  4  digit code: 0-9 decimal, 4'hF blank.
REQ-006 SHALL have port o_rd  output  1  burst strobe to the downstream scroller.
REQ-007 SHALL have port o_err  output  1  one-cycle pulse on framing error, parity error or illegal character.

Function
REQ-008 SHALL pass rx through a two-flop synchronizer before any use; the synchronizer resets to 1.
REQ-009 SHALL receive 8N1 frames LSB first with states IDLE, START, DATA, STOP, BURST.
REQ-010 SHALL move IDLE->START on a synchronized falling edge.
REQ-011 SHALL re-sample in START at CLKS_PER_BIT/2 (integer division): low -> DATA, high -> IDLE (glitch rejected, no o_err).
REQ-012 SHALL sample DATA bits at CLKS_PER_BIT intervals from mid-start, using a 3-bit bit index that wraps 7->0 into STOP.
REQ-013 SHALL sample the stop bit at mid-bit: 1 -> byte accepted; 0 -> byte discarded, o_err pulses one cycle, return IDLE.
REQ-014 SHALL map accepted bytes: 0x30-0x39 -> byte minus 0x30 appended to the 3-entry buffer; 0x20 -> 4'hF appended; 0x0D/0x0A -> terminator; any other -> discarded, o_err pulses.
REQ-015 SHALL enter BURST when the buffer reaches 3 entries, or on a terminator with 1-2 entries, padding the empty slots with 4'hF.
REQ-016 SHALL ignore a terminator received while the buffer is empty (no burst, no o_err).
REQ-017 SHALL, when BURST is entered at cycle T, drive o_rd high on cycles T, T+1, T+2 exactly and low otherwise.
REQ-018 SHALL drive o_dec = entry0 at T+1, entry1 at T+2, entry2 at T+3, and 4'hF at every other time.
REQ-019 SHALL clear the buffer, return to IDLE at T+4, and monitor rx again from T+4.
REQ-020 SHALL not lose a start bit that occurs during BURST (burst length 4 cycles < one bit time).
REQ-021 SHALL never raise o_err in the same cycle that o_rd rises.

Reset
REQ-022 SHALL, while rst is low, hold state IDLE, buffer count 0, all buffer entries 4'hF, bit and baud counters 0, o_dec=4'hF, o_rd=0, o_err=0.
REQ-023 SHALL, on rst asserted mid-frame or mid-burst, abort immediately, discard the partial byte and buffer, and emit no further o_rd pulses.
REQ-024 SHALL, after rst release, wait for a new falling edge; a line already low at release is not a start bit.

Configuration
REQ-025 SHALL use macro UART_PARITY_EN to select parity checking.
REQ-026 SHALL, with UART_PARITY_EN defined, insert a PARITY state between DATA and STOP expecting even parity; on mismatch the byte is discarded, o_err pulses once, and the STOP bit is still consumed.
REQ-027 SHALL, without UART_PARITY_EN, use 8N1 framing with no PARITY state and no parity logic.

Verification
REQ-028 SHALL cover: CLKS_PER_BIT=16, send "123" -> o_rd high 3 cycles; o_dec 1,2,3 on the 3 following cycles; o_err never high.
REQ-029 SHALL cover: send "7",0x0D -> one burst with o_dec 7,F,F; send 0x0D alone -> no burst.
REQ-030 SHALL cover: send "4A5 " -> o_err pulses once at 'A'; burst 4,5,F.
REQ-031 SHALL cover: frame 0x31 with stop bit 0 -> o_err pulse, byte dropped; then "999" -> burst 9,9,9.
REQ-032 SHALL cover: 4-cycle low glitch on rx -> no state advance; rst pulled low during the 2nd data bit of the 2nd character -> o_rd stays 0 and after release "000" -> burst 0,0,0.
REQ-033 SHALL cover: with UART_PARITY_EN, "8" sent with odd parity -> o_err pulse, no buffer entry; with correct parity, "8","8","8" -> burst 8,8,8.
